// File: rtl/noc_pkg.sv
// Shared flit definitions for the 3x3 NoC: type codes, field positions,
// flit builders and the transmitter state encoding.
package noc_pkg;

  localparam logic [1:0] FLIT_HDR  = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;
  localparam logic [1:0] FLIT_HS   = 2'b11;

  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int SRC_HI  = 29;
  localparam int SRC_LO  = 26;
  localparam int DST_HI  = 25;
  localparam int DST_LO  = 22;
  localparam int X_HI    = 3;
  localparam int X_LO    = 2;
  localparam int Y_HI    = 1;
  localparam int Y_LO    = 0;
  localparam int HS_RET  = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HS_REQ,
    ST_HS_WAIT,
    ST_HDR,
    ST_BODY,
    ST_TAIL
  } tx_state_t;

  function automatic logic [31:0] build_flit(input logic [1:0]  ftype,
                                             input logic [3:0]  src,
                                             input logic [3:0]  dst,
                                             input logic [21:0] payload);
    logic [31:0] f;
    f                  = '0;
    f[TYPE_HI:TYPE_LO] = ftype;
    f[SRC_HI:SRC_LO]   = src;
    f[DST_HI:DST_LO]   = dst;
    f[21:0]            = payload;
    return f;
  endfunction

  // The transmitter only ever originates requests, so the return bit stays clear.
  function automatic logic [31:0] build_hs_flit(input logic [3:0] src,
                                                input logic [3:0] dst);
    logic [31:0] f;
    f         = build_flit(FLIT_HS, src, dst, '0);
    f[HS_RET] = 1'b0;
    return f;
  endfunction

  function automatic logic addr_match(input logic [3:0] a, input logic [3:0] b);
    return (a[X_HI:X_LO] == b[X_HI:X_LO]) && (a[Y_HI:Y_LO] == b[Y_HI:Y_LO]);
  endfunction

endpackage

// File: rtl/noc_flit_tx_if.sv
// PE/router-facing signal bundle of the flit transmitter; master is the
// transmitter side, slave is the PE/router environment.
interface noc_flit_tx_if #(
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_dest;
  logic [LEN_W-1:0] req_len;
  logic             data_valid;
  logic             data_ready;
  logic [21:0]      data_in;
  logic             grant;
  logic             flit_valid;
  logic [31:0]      flit_out;
  logic             hs_ret_valid;
  logic [3:0]       hs_ret_src;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  req_valid, req_dest, req_len, data_valid, data_in, grant,
           hs_ret_valid, hs_ret_src,
    output req_ready, data_ready, flit_valid, flit_out, busy, done, err
  );

  modport slave (
    output req_valid, req_dest, req_len, data_valid, data_in, grant,
           hs_ret_valid, hs_ret_src,
    input  req_ready, data_ready, flit_valid, flit_out, busy, done, err
  );
endinterface

// File: rtl/noc_flit_tx_fsm.sv
// Packet sequencing for the flit transmitter: state, handshake retry and
// timeout counters, body count, and the flit-register load strobes.
module noc_flit_tx_fsm
  import noc_pkg::*;
#(
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             flit_valid,
  input  logic             grant,
  input  logic             data_valid,
  input  logic             hs_ret_valid,
  input  logic [3:0]       hs_ret_src,
  input  logic [3:0]       dest_q,
  input  logic [LEN_W-1:0] len_q,
  output logic             accept,
  output logic             load_hs,
  output logic             load_hdr,
  output logic             load_body,
  output logic             load_tail,
  output logic             req_ready,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  tx_state_t          state_q, state_n;
  logic [TMO_W-1:0]   tmo_q, tmo_n;
  logic [RETRY_W-1:0] retry_q, retry_n;
  logic [LEN_W-1:0]   cnt_q, cnt_n;
  logic               slot_free;
  logic               granted;

  assign slot_free = !flit_valid || grant;
  assign granted   = flit_valid && grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      tmo_q   <= tmo_n;
      retry_q <= retry_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    tmo_n      = tmo_q;
    retry_n    = retry_q;
    cnt_n      = cnt_q;
    accept     = 1'b0;
    load_hs    = 1'b0;
    load_hdr   = 1'b0;
    load_body  = 1'b0;
    load_tail  = 1'b0;
    req_ready  = 1'b0;
    data_ready = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        req_ready = !flit_valid && !rst;
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          load_hs = 1'b1;
          retry_n = '0;
          state_n = ST_HS_REQ;
        end
      end
      ST_HS_REQ: begin
        if (granted) begin
          tmo_n   = '0;
          state_n = ST_HS_WAIT;
        end
      end
      // A matching return beats a timeout landing in the same cycle.
      ST_HS_WAIT: begin
        if (hs_ret_valid && addr_match(hs_ret_src, dest_q)) begin
          load_hdr = 1'b1;
          state_n  = ST_HDR;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_n = retry_q + 1'b1;
            load_hs = 1'b1;
            state_n = ST_HS_REQ;
          end else begin
            err     = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          tmo_n = tmo_q + 1'b1;
        end
      end
      ST_HDR: begin
        if (granted) begin
          cnt_n = '0;
          if (len_q == '0) begin
            load_tail = 1'b1;
            state_n   = ST_TAIL;
          end else begin
            state_n = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (cnt_q == len_q) begin
          if (slot_free) begin
            load_tail = 1'b1;
            state_n   = ST_TAIL;
          end
        end else begin
          data_ready = data_valid && slot_free;
          if (data_ready) begin
            load_body = 1'b1;
            cnt_n     = cnt_q + 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (granted) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/noc_flit_tx.sv
// PE-side NoC flit transmitter: handshake, header, body and tail into the
// router local port. Define NOC_TX_CHECKSUM_EN to carry a body XOR in the tail.
module noc_flit_tx
  import noc_pkg::*;
#(
  parameter logic [3:0] ADDR_SW   = 4'b0000,
  parameter int         LEN_W     = 4,
  parameter int         TIMEOUT   = 64,
  parameter int         MAX_RETRY = 3
) (
  input logic           clk,
  input logic           rst,
  noc_flit_tx_if.master bus
);

  logic             accept, load_hs, load_hdr, load_body, load_tail, load_any;
  logic             req_ready, data_ready, busy, done, err;
  logic             flit_valid_q;
  logic [31:0]      flit_q, next_flit;
  logic [3:0]       dest_q;
  logic [LEN_W-1:0] len_q;
  logic [21:0]      tail_payload;
  logic             slot_free;

  noc_flit_tx_fsm #(
    .LEN_W    (LEN_W),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (bus.req_valid),
    .flit_valid  (flit_valid_q),
    .grant       (bus.grant),
    .data_valid  (bus.data_valid),
    .hs_ret_valid(bus.hs_ret_valid),
    .hs_ret_src  (bus.hs_ret_src),
    .dest_q      (dest_q),
    .len_q       (len_q),
    .accept      (accept),
    .load_hs     (load_hs),
    .load_hdr    (load_hdr),
    .load_body   (load_body),
    .load_tail   (load_tail),
    .req_ready   (req_ready),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  assign slot_free = !flit_valid_q || bus.grant;
  assign load_any  = load_hs || load_hdr || load_body || load_tail;

`ifdef NOC_TX_CHECKSUM_EN
  logic [21:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)            csum_q <= '0;
    else if (load_hdr)  csum_q <= '0;
    else if (load_body) csum_q <= csum_q ^ bus.data_in;
  end

  assign tail_payload = csum_q;
`else
  assign tail_payload = '0;
`endif

  // The request flit is built in the accept cycle, before dest_q is updated.
  always_comb begin
    next_flit = '0;
    if (load_hs)
      next_flit = build_hs_flit(ADDR_SW, accept ? bus.req_dest : dest_q);
    else if (load_hdr)
      next_flit = build_flit(FLIT_HDR, ADDR_SW, dest_q, 22'(len_q));
    else if (load_body)
      next_flit = build_flit(FLIT_BODY, ADDR_SW, dest_q, bus.data_in);
    else if (load_tail)
      next_flit = build_flit(FLIT_TAIL, ADDR_SW, dest_q, tail_payload);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      dest_q       <= '0;
      len_q        <= '0;
    end else begin
      if (accept) begin
        dest_q <= bus.req_dest;
        len_q  <= bus.req_len;
      end
      if (slot_free) begin
        flit_valid_q <= load_any;
        if (load_any) flit_q <= next_flit;
      end
    end
  end

  assign bus.flit_valid = flit_valid_q;
  assign bus.flit_out   = flit_q;
  assign bus.req_ready  = req_ready;
  assign bus.data_ready = data_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed bench for noc_flit_tx (ADDR_SW=0101, TIMEOUT=8, MAX_RETRY=3);
// expected tails follow NOC_TX_CHECKSUM_EN when it is defined.
module tb_noc_flit_tx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  noc_flit_tx_if #(.LEN_W(4)) bus ();

  noc_flit_tx #(
    .ADDR_SW  (4'b0101),
    .LEN_W    (4),
    .TIMEOUT  (8),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef NOC_TX_CHECKSUM_EN
  localparam logic [31:0] T1_TAIL = 32'h56BE23B4;
  localparam logic [31:0] T4_TAIL = 32'h568000DD;
  localparam logic [31:0] T6_TAIL = 32'h568000FF;
`else
  localparam logic [31:0] T1_TAIL = 32'h56800000;
  localparam logic [31:0] T4_TAIL = 32'h56800000;
  localparam logic [31:0] T6_TAIL = 32'h56800000;
`endif

  int          checks   = 0;
  int          passed   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          n_payload = 0;
  logic [31:0] flit_log[$];
  logic [21:0] data_log[$];
  logic [21:0] payload[16];

  // Granted flits, consumed payloads and status pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.flit_valid && bus.grant) flit_log.push_back(bus.flit_out);
      if (bus.data_valid && bus.data_ready) data_log.push_back(bus.data_in);
      if (bus.done) done_cnt++;
      if (bus.err)  err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] dest,
                               input logic [3:0] len);
    bus.req_valid = valid;
    bus.req_dest  = dest;
    bus.req_len   = len;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    if (data_log.size() < n_payload) begin
      bus.data_valid = 1'b1;
      bus.data_in    = payload[data_log.size()];
    end else begin
      bus.data_valid = 1'b0;
      bus.data_in    = '0;
    end
  endtask

  task automatic new_test();
    flit_log.delete();
    data_log.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic start_packet(input logic [3:0] dest, input logic [3:0] len,
                              input int wait_cycles);
    applyStimulus(1'b1, dest, len);
    run_cycle();
    applyStimulus(1'b0, 4'h0, 4'h0);
    repeat (wait_cycles) run_cycle();
    bus.hs_ret_valid = 1'b1;
    bus.hs_ret_src   = dest;
    run_cycle();
    bus.hs_ret_valid = 1'b0;
    bus.hs_ret_src   = 4'h0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      run_cycle();
      k++;
    end
    checkOutput(tag, done_cnt, 1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0, 4'h0);
    bus.data_valid   = 1'b0;
    bus.data_in      = '0;
    bus.grant        = 1'b0;
    bus.hs_ret_valid = 1'b0;
    bus.hs_ret_src   = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_flit_valid", bus.flit_valid, 0);
    checkOutput("rst_flit_out", bus.flit_out, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_data_ready", bus.data_ready, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    rst = 1'b0;
    bus.grant = 1'b1;
    #1;
    checkOutput("idle_req_ready", bus.req_ready, 1);

    $display("[TB] len=2 packet, return on 5th wait cycle");
    new_test();
    payload[0] = 22'h012345;
    payload[1] = 22'h3F00F1;
    n_payload  = 2;
    applyStimulus(1'b1, 4'b1010, 4'd2);
    run_cycle();
    applyStimulus(1'b0, 4'h0, 4'h0);
    checkOutput("t1_hs_valid_latency", bus.flit_valid, 1);
    checkOutput("t1_hs_flit", bus.flit_out, 32'hD6800000);
    checkOutput("t1_busy", bus.busy, 1);
    repeat (5) run_cycle();
    checkOutput("t1_wait_slot_empty", bus.flit_valid, 0);
    bus.hs_ret_valid = 1'b1;
    bus.hs_ret_src   = 4'b1010;
    run_cycle();
    bus.hs_ret_valid = 1'b0;
    bus.hs_ret_src   = 4'h0;
    checkOutput("t1_hdr_flit", bus.flit_out, 32'h96800002);
    wait_done("t1_done", 50);
    checkOutput("t1_flit_count", flit_log.size(), 5);
    if (flit_log.size() == 5) begin
      checkOutput("t1_log_hs", flit_log[0], 32'hD6800000);
      checkOutput("t1_log_hdr", flit_log[1], 32'h96800002);
      checkOutput("t1_log_body0", flit_log[2], 32'h16812345);
      checkOutput("t1_log_body1", flit_log[3], 32'h16BF00F1);
      checkOutput("t1_log_tail", flit_log[4], T1_TAIL);
    end
    repeat (3) run_cycle();
    checkOutput("t1_done_once", done_cnt, 1);
    checkOutput("t1_no_err", err_cnt, 0);
    checkOutput("t1_idle_busy", bus.busy, 0);
    checkOutput("t1_idle_ready", bus.req_ready, 1);

    $display("[TB] len=0 packet with data held valid");
    new_test();
    payload[0] = 22'h155555;
    n_payload  = 1;
    start_packet(4'b1010, 4'd0, 2);
    wait_done("t2_done", 50);
    checkOutput("t2_flit_count", flit_log.size(), 3);
    if (flit_log.size() == 3) begin
      checkOutput("t2_log_hs", flit_log[0], 32'hD6800000);
      checkOutput("t2_log_hdr", flit_log[1], 32'h96800000);
      checkOutput("t2_log_tail", flit_log[2], 32'h56800000);
    end
    checkOutput("t2_no_payload_taken", data_log.size(), 0);

    $display("[TB] no return: retries then abort");
    new_test();
    n_payload = 0;
    applyStimulus(1'b1, 4'b1010, 4'd1);
    run_cycle();
    applyStimulus(1'b0, 4'h0, 4'h0);
    k = 0;
    while (err_cnt == 0 && k < 100) begin
      run_cycle();
      k++;
    end
    checkOutput("t3_err_pulse", err_cnt, 1);
    checkOutput("t3_hs_count", flit_log.size(), 4);
    for (int i = 0; i < flit_log.size(); i++)
      checkOutput("t3_hs_flit", flit_log[i], 32'hD6800000);
    run_cycle();
    checkOutput("t3_err_once", err_cnt, 1);
    checkOutput("t3_no_done", done_cnt, 0);
    checkOutput("t3_idle_busy", bus.busy, 0);
    checkOutput("t3_idle_ready", bus.req_ready, 1);

    $display("[TB] grant stall on 2nd body flit");
    new_test();
    payload[0] = 22'h0000AA;
    payload[1] = 22'h0000BB;
    payload[2] = 22'h0000CC;
    n_payload  = 3;
    start_packet(4'b1010, 4'd3, 1);
    k = 0;
    while (!(bus.flit_valid && bus.flit_out == 32'h168000BB) && k < 50) begin
      run_cycle();
      k++;
    end
    checkOutput("t4_stall_reached", bus.flit_out, 32'h168000BB);
    bus.grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t4_stall_valid", bus.flit_valid, 1);
      checkOutput("t4_stall_hold", bus.flit_out, 32'h168000BB);
      checkOutput("t4_stall_data_ready", bus.data_ready, 0);
      run_cycle();
    end
    bus.grant = 1'b1;
    wait_done("t4_done", 50);
    checkOutput("t4_flit_count", flit_log.size(), 6);
    checkOutput("t4_payload_count", data_log.size(), 3);
    if (flit_log.size() == 6) begin
      checkOutput("t4_log_hdr", flit_log[1], 32'h96800003);
      checkOutput("t4_log_body0", flit_log[2], 32'h168000AA);
      checkOutput("t4_log_body1", flit_log[3], 32'h168000BB);
      checkOutput("t4_log_body2", flit_log[4], 32'h168000CC);
      checkOutput("t4_log_tail", flit_log[5], T4_TAIL);
    end

    $display("[TB] wrong source, then match on the timeout cycle");
    new_test();
    payload[0] = 22'h2AAAAA;
    n_payload  = 1;
    applyStimulus(1'b1, 4'b1010, 4'd1);
    run_cycle();
    applyStimulus(1'b0, 4'h0, 4'h0);
    run_cycle();
    run_cycle();
    bus.hs_ret_valid = 1'b1;
    bus.hs_ret_src   = 4'b0000;
    run_cycle();
    bus.hs_ret_valid = 1'b0;
    repeat (5) run_cycle();
    checkOutput("t5_wrong_src_ignored", flit_log.size(), 1);
    checkOutput("t5_still_waiting", bus.flit_valid, 0);
    bus.hs_ret_valid = 1'b1;
    bus.hs_ret_src   = 4'b1010;
    run_cycle();
    bus.hs_ret_valid = 1'b0;
    bus.hs_ret_src   = 4'h0;
    checkOutput("t5_hdr_not_retry", bus.flit_out, 32'h96800001);
    wait_done("t5_done", 50);
    checkOutput("t5_flit_count", flit_log.size(), 4);

    $display("[TB] reset in BODY, then a fresh packet");
    new_test();
    payload[0] = 22'h111111;
    payload[1] = 22'h222222;
    payload[2] = 22'h333333;
    payload[3] = 22'h3FFFFF;
    n_payload  = 4;
    start_packet(4'b1010, 4'd4, 1);
    k = 0;
    while (data_log.size() < 2 && k < 50) begin
      run_cycle();
      k++;
    end
    rst = 1'b1;
    run_cycle();
    checkOutput("t6_rst_flit_valid", bus.flit_valid, 0);
    checkOutput("t6_rst_busy", bus.busy, 0);
    rst = 1'b0;
    #1;
    checkOutput("t6_ready_after_rst", bus.req_ready, 1);
    checkOutput("t6_no_done", done_cnt, 0);
    new_test();
    payload[0] = 22'h00000F;
    payload[1] = 22'h0000F0;
    n_payload  = 2;
    start_packet(4'b1010, 4'd2, 1);
    wait_done("t6_done", 50);
    checkOutput("t6_flit_count", flit_log.size(), 5);
    if (flit_log.size() == 5) begin
      checkOutput("t6_log_body0", flit_log[2], 32'h1680000F);
      checkOutput("t6_log_body1", flit_log[3], 32'h168000F0);
      checkOutput("t6_log_tail", flit_log[4], T6_TAIL);
    end

    $display("[TB] maximum length packet");
    new_test();
    for (int i = 0; i < 15; i++) payload[i] = 22'(i + 1);
    n_payload = 15;
    start_packet(4'b1010, 4'd15, 1);
    wait_done("t7_done", 100);
    checkOutput("t7_flit_count", flit_log.size(), 18);
    if (flit_log.size() == 18) begin
      checkOutput("t7_log_hdr", flit_log[1], 32'h9680000F);
      checkOutput("t7_log_last_body", flit_log[16], 32'h1680000F);
      checkOutput("t7_log_tail", flit_log[17], 32'h56800000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
